d_register_bank: RTL and testbench

D_REGISTER_BANK -- requirements
Module: d_register_bank

---
 rtl/d_register_bank_pkg.sv | 14 +
 rtl/d_register_bank_if.sv | 30 +++
 rtl/d_register_bank_reg.sv | 36 +++
 rtl/d_register_bank.sv | 106 ++++++++++
 tb/tb_d_register_bank.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/d_register_bank_pkg.sv
// Shared types and default parameters for the register bank slice.
package reg_bank_pkg;

    // Scan controller states: IDLE accepts writes, SCAN streams every channel out.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam bit DEF_BYPASS   = 1'b1;

endpackage

// File: rtl/d_register_bank_if.sv
// Write/read/scan bus of the register bank; master drives requests, slave is the bank.
interface d_register_bank_if
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEF_CHANNELS)
);
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_notq;
    logic             scan_start;
    logic             scan_busy;
    logic             scan_valid;
    logic [WIDTH-1:0] scan_data;
    logic             scan_last;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_addr, scan_start,
        input  wr_ready, rd_q, rd_notq, scan_busy, scan_valid, scan_data, scan_last
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_addr, scan_start,
        output wr_ready, rd_q, rd_notq, scan_busy, scan_valid, scan_data, scan_last
    );
endinterface

// File: rtl/d_register_bank_reg.sv
// One storage channel: WIDTH-bit register with load enable and synchronous clear.
module d_register
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next value: load on enable, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // Storage flop; clear takes priority over a load in the same cycle.
    // NOTE: every channel is a real flop bank, so it can be cleared; this is not an inferred RAM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so all channels and the FSM update from the same pre-edge values.
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/d_register_bank.sv
// Register bank: CHANNELS x WIDTH storage, zero-latency read with optional
// write bypass, and a serial scan that dumps every channel one beat per cycle.
module d_register_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter bit BYPASS   = DEF_BYPASS
) (
    input logic               clk,
    input logic               reset,
    d_register_bank_if.slave  bus
);
    localparam int          AW       = $clog2(CHANNELS);
    localparam logic [AW-1:0] LAST_IDX = AW'(CHANNELS - 1);

    scan_state_e      state_q;
    logic [AW-1:0]    idx_q;
    logic [WIDTH-1:0] stored [CHANNELS];
    logic [CHANNELS-1:0] wr_en;
    logic             wr_fire;
    logic             bypass_hit;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] scan_val;

    // Writes are only taken outside a scan, so the dump is a consistent snapshot.
    assign bus.wr_ready = (state_q == IDLE);
    assign wr_fire      = bus.wr_valid && bus.wr_ready;

    // One register per channel; an address beyond the last channel enables nothing.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign wr_en[g] = wr_fire && (bus.wr_addr == AW'(g));

        d_register #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en_i  (wr_en[g]),
            .d_i   (bus.wr_data),
            .q_o   (stored[g])
        );
    end

    // Forward the write data when it lands on the channel being read (reset discards it).
    assign bypass_hit = BYPASS && !reset && (|wr_en) && (bus.wr_addr == bus.rd_addr);

    // Read mux: unmapped addresses read as zero.
    always_comb begin
        // NOTE: default first so every path assigns rd_val and no latch is inferred.
        rd_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                rd_val = stored[i];
            end
        end
        if (bypass_hit) begin
            rd_val = bus.wr_data;
        end
    end

    assign bus.rd_q    = rd_val;
    assign bus.rd_notq = ~rd_val;

    // Scan mux: selected channel while scanning, zero while idle.
    always_comb begin
        scan_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_q == SCAN && idx_q == AW'(i)) begin
                scan_val = stored[i];
            end
        end
    end

    assign bus.scan_busy  = (state_q == SCAN);
    assign bus.scan_valid = (state_q == SCAN);
    assign bus.scan_data  = scan_val;
    assign bus.scan_last  = (state_q == SCAN) && (idx_q == LAST_IDX);

    // Scan controller: start from IDLE, walk idx over all channels, then drop back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.scan_start) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_d_register_bank.sv
// Bench for d_register_bank: three instances (bypass, no bypass, three channels)
// driven in lockstep and compared against an array-based reference model.
module tb_d_register_bank;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    d_register_bank_if #(.WIDTH(8), .AW(2)) if_a ();
    d_register_bank_if #(.WIDTH(8), .AW(2)) if_b ();
    d_register_bank_if #(.WIDTH(8), .AW(2)) if_c ();

    d_register_bank #(.WIDTH(8), .CHANNELS(4), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );
    d_register_bank #(.WIDTH(8), .CHANNELS(4), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );
    d_register_bank #(.WIDTH(8), .CHANNELS(3), .BYPASS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: channel contents per instance, plus the scan position of dut_a.
    int m [3][4];
    int chans [3] = '{4, 4, 3};
    bit byp   [3] = '{1'b1, 1'b0, 1'b1};
    bit s_act = 1'b0;
    int s_pos = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit wv, input int wa, input int wd,
                         input int ra, input bit ss);
        reset = rst;
        if_a.wr_valid = wv; if_a.wr_addr = 2'(wa); if_a.wr_data = 8'(wd);
        if_a.rd_addr = 2'(ra); if_a.scan_start = ss;
        if_b.wr_valid = wv; if_b.wr_addr = 2'(wa); if_b.wr_data = 8'(wd);
        if_b.rd_addr = 2'(ra); if_b.scan_start = 1'b0;
        if_c.wr_valid = wv; if_c.wr_addr = 2'(wa); if_c.wr_data = 8'(wd);
        if_c.rd_addr = 2'(ra); if_c.scan_start = 1'b0;
    endtask

    // One cycle: drive after the falling edge, check the combinational view,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input bit rst, input bit wv, input int wa, input int wd,
                        input int ra, input bit ss);
        logic [7:0] obs_q [3];
        logic [7:0] obs_n [3];
        bit acc [3];
        int exp;
        @(negedge clk);
        drive(rst, wv, wa, wd, ra, ss);
        #2;
        obs_q = '{if_a.rd_q, if_b.rd_q, if_c.rd_q};
        obs_n = '{if_a.rd_notq, if_b.rd_notq, if_c.rd_notq};
        for (int k = 0; k < 3; k++) begin
            acc[k] = !rst && wv && (wa < chans[k]) && ((k != 0) || !s_act);
            if (ra >= chans[k]) exp = 0;
            else if (byp[k] && acc[k] && wa == ra) exp = wd;
            else exp = m[k][ra];
            check($sformatf("rd_q[dut%0d,a%0d]", k, ra), 32'(obs_q[k]), 32'(exp));
            check($sformatf("rd_notq[dut%0d,a%0d]", k, ra), 32'(obs_n[k]), 32'(~exp & 'hFF));
        end
        check("wr_ready", 32'(if_a.wr_ready), 32'(!s_act));
        check("scan_busy", 32'(if_a.scan_busy), 32'(s_act));
        check("scan_valid", 32'(if_a.scan_valid), 32'(s_act));
        check("scan_data", 32'(if_a.scan_data), 32'(s_act ? m[0][s_pos] : 0));
        check("scan_last", 32'(if_a.scan_last), 32'(s_act && s_pos == 3));
        if (rst) begin
            m = '{default: 0};
            s_act = 1'b0;
            s_pos = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) m[k][wa] = wd;
            end
            if (s_act) begin
                if (s_pos == 3) begin
                    s_act = 1'b0;
                    s_pos = 0;
                end else begin
                    s_pos++;
                end
            end else if (ss) begin
                s_act = 1'b1;
                s_pos = 0;
            end
        end
    endtask

    initial begin
        m = '{default: 0};
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        // Reset for two cycles; a write and scan_start alongside it are discarded.
        step(1, 1, 2, 'h77, 2, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, a, 0);
        // Write then read back every channel.
        step(0, 1, 2, 'hA5, 0, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, a, 0);
        // Same-cycle read of the written channel: new data only with bypass.
        step(0, 1, 1, 'h3C, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // Load a pattern; the last write coincides with scan_start.
        step(0, 1, 0, 'h11, 0, 0);
        step(0, 1, 1, 'h22, 1, 0);
        step(0, 1, 2, 'h33, 2, 0);
        step(0, 1, 3, 'h44, 3, 1);
        // Writes held during the four beats are refused, then taken once idle.
        repeat (4) step(0, 1, 0, 'hFF, 0, 0);
        step(0, 1, 0, 'hFF, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // scan_start held across a whole scan: idle one cycle, then restart.
        repeat (6) step(0, 0, 0, 0, 2, 1);
        repeat (4) step(0, 0, 0, 0, 3, 0);
        // Reset on beat 2 aborts the scan and clears the bank.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, a, 0);
        // Address 3 is unmapped on the three-channel instance.
        step(0, 1, 3, 'h5A, 3, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, a, 0);
        // Randomized traffic.
        repeat (400) begin
            step($urandom_range(31, 0) == 0, 1'($urandom_range(1, 0)),
                 int'($urandom_range(3, 0)), int'($urandom_range(255, 0)),
                 int'($urandom_range(3, 0)), $urandom_range(5, 0) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
